// File: rtl/pc_branch_unit.sv
// Program-counter unit: holds the PC, resolves branch/JAL/JALR targets and next-PC,
// with stall, redirect pulses, a misaligned-target trap (EPC capture) and a timed flush.
module pc_branch_unit #(
    parameter int              XLEN         = 32,
    parameter int              IMM_SHIFT    = 1,
    parameter int              ALIGN_BITS   = 2,
    parameter int              INSTR_BYTES  = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_en,
    input  logic            br_taken,
    input  logic            jal_en,
    input  logic            jalr_en,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] link_out,
    output logic [XLEN-1:0] target_out,
    output logic            redirect,
    output logic            flush,
    output logic            misaligned,
    output logic [XLEN-1:0] epc
);

    localparam int              CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [XLEN-1:0] PC_INC   = XLEN'(INSTR_BYTES);

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  epc_q;
    logic             redirect_q;
    logic             flush_q;
    logic             misaligned_q;

    logic [XLEN-1:0]  pcrel;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  jalr_t;
    logic [XLEN-1:0]  target;
    logic             take;
    logic             mis;

    // All target arithmetic wraps modulo 2^XLEN; carries are intentionally dropped.
    assign pcrel    = pc_q + (imm << IMM_SHIFT);
    assign jalr_sum = rs1 + imm;
    assign jalr_t   = {jalr_sum[XLEN-1:1], 1'b0};

    always_comb begin
        // NOTE: assign a default before the conditional override so no path infers a latch.
        target = pcrel;
        if (jalr_en) begin
            target = jalr_t;
        end
    end

    assign take = jalr_en | jal_en | (br_en & br_taken);
    assign mis  = take & (|target[ALIGN_BITS-1:0]);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            redirect_q   <= 1'b0;
            flush_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            redirect_q   <= 1'b0;
            misaligned_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (!stall) begin
                        if (mis) begin
                            pc_q         <= TRAP_VECTOR;
                            epc_q        <= pc_q;
                            misaligned_q <= 1'b1;
                            flush_q      <= 1'b1;
                            cnt_q        <= CNT_INIT;
                            state_q      <= ST_FLUSH;
                        end else if (take) begin
                            pc_q       <= target;
                            redirect_q <= 1'b1;
                        end else begin
                            pc_q <= pc_q + PC_INC;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Stall and control inputs are ignored; the PC stays parked on the trap vector.
                    if (cnt_q == '0) begin
                        state_q <= ST_RUN;
                        flush_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign pc_out     = pc_q;
    assign link_out   = pc_q + PC_INC;
    assign target_out = target;
    assign redirect   = redirect_q;
    assign flush      = flush_q;
    assign misaligned = misaligned_q;
    assign epc        = epc_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: a vector table for single-cycle target/next-PC
// behaviour plus hand sequences for reset, trap/flush, stall and reset-during-flush.
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_en = 1'b0;
    logic        br_taken = 1'b0;
    logic        jal_en = 1'b0;
    logic        jalr_en = 1'b0;
    logic [31:0] imm = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] pc_out;
    logic [31:0] link_out;
    logic [31:0] target_out;
    logic        redirect;
    logic        flush;
    logic        misaligned;
    logic [31:0] epc;

    int n_checks = 0;
    int n_errors = 0;

    pc_branch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_en      (br_en),
        .br_taken   (br_taken),
        .jal_en     (jal_en),
        .jalr_en    (jalr_en),
        .imm        (imm),
        .rs1        (rs1),
        .pc_out     (pc_out),
        .link_out   (link_out),
        .target_out (target_out),
        .redirect   (redirect),
        .flush      (flush),
        .misaligned (misaligned),
        .epc        (epc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        br_en;
        logic        br_taken;
        logic        jal_en;
        logic        jalr_en;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] exp_target;
        logic [31:0] exp_link;
        logic [31:0] exp_next;
        logic        exp_redirect;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic be, input logic bt, input logic je,
                         input logic jre, input logic [31:0] im, input logic [31:0] r);
        stall    = s;
        br_en    = be;
        br_taken = bt;
        jal_en   = je;
        jalr_en  = jre;
        imm      = im;
        rs1      = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Jump to an aligned address with a JALR so the next cycle starts from a known PC.
    task automatic set_pc(input logic [31:0] addr);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, addr);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        vecs[0] = '{"br_taken",    32'h0000_0100, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0,
                    32'h0000_0120, 32'h0000_0104, 32'h0000_0120, 1'b1};
        vecs[1] = '{"br_not_taken", 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,
                    32'h0000_0120, 32'h0000_0104, 32'h0000_0104, 1'b0};
        vecs[2] = '{"jalr_over_jal", 32'h0000_0200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0003, 32'h0000_1001,
                    32'h0000_1004, 32'h0000_0204, 32'h0000_1004, 1'b1};
        vecs[3] = '{"pcrel_neg_wrap", 32'h0000_0010, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0,
                    32'h0000_0000, 32'h0000_0014, 32'h0000_0000, 1'b1};
        vecs[4] = '{"taken_no_en", 32'h0000_0040, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0,
                    32'h0000_0050, 32'h0000_0044, 32'h0000_0044, 1'b0};
        vecs[5] = '{"jalr_lsb_clr", 32'h0000_0080, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0501,
                    32'h0000_0500, 32'h0000_0084, 32'h0000_0500, 1'b1};
        vecs[6] = '{"jal_with_br", 32'h0000_0400, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h0,
                    32'h0000_0440, 32'h0000_0404, 32'h0000_0440, 1'b1};
        vecs[7] = '{"idle_seq",    32'h0000_0600, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'h0,
                    32'h0000_0608, 32'h0000_0604, 32'h0000_0604, 1'b0};
        vecs[8] = '{"pc_wrap",     32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0,
                    32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b0};

        // Reset, then free-run from the reset vector.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_pc", pc_out, 32'h0);
        check("rst_redirect", {31'b0, redirect}, 32'h0);
        check("rst_flush", {31'b0, flush}, 32'h0);
        check("rst_misaligned", {31'b0, misaligned}, 32'h0);
        check("rst_epc", epc, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("run_pc", pc_out, 32'(i * 4));
            check("run_flush", {31'b0, flush}, 32'h0);
            check("run_redirect", {31'b0, redirect}, 32'h0);
        end

        // Single-cycle vectors.
        for (int i = 0; i < 9; i++) begin
            set_pc(vecs[i].pc);
            check({vecs[i].name, "_start_pc"}, pc_out, vecs[i].pc);
            drive(1'b0, vecs[i].br_en, vecs[i].br_taken, vecs[i].jal_en, vecs[i].jalr_en,
                  vecs[i].imm, vecs[i].rs1);
            #1;
            check({vecs[i].name, "_target"}, target_out, vecs[i].exp_target);
            check({vecs[i].name, "_link"}, link_out, vecs[i].exp_link);
            tick();
            check({vecs[i].name, "_pc"}, pc_out, vecs[i].exp_next);
            check({vecs[i].name, "_redirect"}, {31'b0, redirect}, {31'b0, vecs[i].exp_redirect});
            check({vecs[i].name, "_misaligned"}, {31'b0, misaligned}, 32'h0);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        end

        // Misaligned JAL: trap, two flush cycles with stall and control inputs ignored.
        set_pc(32'h0000_0300);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0001, 32'h0);
        #1;
        check("trap_target", target_out, 32'h0000_0302);
        tick();
        check("trap_pc", pc_out, 32'h0000_0100);
        check("trap_epc", epc, 32'h0000_0300);
        check("trap_misaligned", {31'b0, misaligned}, 32'h1);
        check("trap_redirect", {31'b0, redirect}, 32'h0);
        check("trap_flush1", {31'b0, flush}, 32'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        tick();
        check("flush2_pc", pc_out, 32'h0000_0100);
        check("flush2_misaligned", {31'b0, misaligned}, 32'h0);
        check("flush2_flush", {31'b0, flush}, 32'h1);
        tick();
        check("flush_exit_flush", {31'b0, flush}, 32'h0);
        check("flush_exit_pc", pc_out, 32'h0000_0100);
        check("flush_exit_redirect", {31'b0, redirect}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("post_flush_pc", pc_out, 32'h0000_0104);
        check("post_flush_epc", epc, 32'h0000_0300);

        // Stall with a pending JAL: PC frozen, no redirect, then normal advance.
        set_pc(32'h0000_0500);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", pc_out, 32'h0000_0500);
            check("stall_redirect", {31'b0, redirect}, 32'h0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("unstall_pc", pc_out, 32'h0000_0504);

        // Misaligned JALR (after LSB clear), then reset in the middle of FLUSH.
        set_pc(32'h0000_0700);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0103);
        #1;
        check("jalr_mis_target", target_out, 32'h0000_0102);
        tick();
        check("jalr_mis_pc", pc_out, 32'h0000_0100);
        check("jalr_mis_epc", epc, 32'h0000_0700);
        check("jalr_mis_flag", {31'b0, misaligned}, 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_flush_pc", pc_out, 32'h0);
        check("rst_flush_flush", {31'b0, flush}, 32'h0);
        check("rst_flush_epc", epc, 32'h0);
        tick();
        check("rst_flush_run_pc", pc_out, 32'h0000_0004);
        check("rst_flush_run_flush", {31'b0, flush}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
